traffic_phase_scheduler: RTL
============================

// Module: traffic_phase_scheduler
// PURPOSE
//  Timed phase scheduler for the main/farm road intersection. Shares the crossing between three
//  requesters: main-road traffic (default owner), farm-road cars and a pedestrian button.
//  Enforces minimum/maximum green, yellow and all-red clearance times, and round-robins farm vs pedestrian.
//  Drives the two light heads and the walk lamp directly.
// PARAMETERS
//  MIN_GREEN  8   min cycles any green (main or farm) is held before it may yield
//  MAX_GREEN  16  max cycles farm green is held while car_farm_road stays high
//  YELLOW_T   3   cycles in each yellow phase
//  ALLRED_T   2   cycles in each all-red clearance phase
//  WALK_T     6   cycles the walk lamp is on
//  CNT_W      5   phase timer width; must hold max(all times)-1
// PORTS
//  clk            in   1  clock; all logic on posedge
//  reset          in   1  synchronous reset, active-low
//  car_farm_road  in   1  level: farm-road car waiting
//  ped_req        in   1  pulse/level: pedestrian button, latched internally
//  Main_road      out  2  main head: RED=0 YELLOW=1 GREEN=2
//  Farm_road      out  2  farm head: same coding
//  walk           out  1  pedestrian walk lamp
//  ped_pending    out  1  latched pedestrian request awaiting service
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. When reset==0 at posedge: state=MAIN_G, cnt=0,
//    ped_pending=0, rr=FARM-first. Outputs are Moore decode of state: Main=GREEN Farm=RED walk=0.
//  - cnt: 0 on first cycle in a state, +1 per cycle, saturates at all-ones; cleared on every transition.
//    "done(T)" = (cnt == T-1). Fixed phases last exactly T cycles.
//  - States / outputs (Main,Farm,walk) / transitions:
//    MAIN_G  (G,R,0): if cnt>=MIN_GREEN-1 and (car_farm_road or ped_pending) -> MAIN_Y; else stay.
//    MAIN_Y  (Y,R,0): done(YELLOW_T) -> AR_GRANT.
//    AR_GRANT(R,R,0): done(ALLRED_T) -> grant: both pending -> rr side; only farm -> FARM_G;
//                     only ped -> WALK; neither (car left) -> MAIN_G. rr toggles to other side on
//                     each farm/ped grant.
//    FARM_G  (R,G,0): cnt>=MIN_GREEN-1 and (!car_farm_road or cnt==MAX_GREEN-1) -> FARM_Y.
//    FARM_Y  (R,Y,0): done(YELLOW_T) -> AR_MAIN.
//    WALK    (R,R,1): done(WALK_T) -> AR_MAIN.
//    AR_MAIN (R,R,0): done(ALLRED_T) -> MAIN_G (main always served between side grants).
//    Illegal encoding -> MAIN_G next cycle.
//  - Request sampling: car_farm_road and ped_pending are sampled on the decision cycle only.
//  - ped_pending: set when ped_req==1; cleared on the transition into WALK. Clear wins over a
//    simultaneous ped_req; ped_req while in WALK is ignored. Farm requests are not latched.
//  - Never two greens, never green/walk together; every green->other-green passes yellow+all-red.
//  - Reset mid-phase: next cycle is MAIN_G cnt=0 regardless of state; latched ped request dropped.
//  - Latency: request already present -> MAIN_Y at earliest on cycle MIN_GREEN of main green.
// STRUCTURE
//  - traffic_pkg: light codes RED/YELLOW/GREEN (2-bit), phase state encodings (3-bit), rr side consts.
//  - Sub-module phase_timer (clr, cnt out, saturating, CNT_W param); FSM, ped latch, rr and decode in top.
// TESTING (defaults)
//  - Reset held 3 cycles with car_farm_road=1 -> Main=2 Farm=0 walk=0 throughout; cnt=0 after release.
//  - car_farm_road=1 from reset release -> MAIN_G 8 cyc, MAIN_Y 3, AR 2, FARM_G; drop car at
//    farm cycle 3 -> FARM_G still 8 cyc total, then FARM_Y 3, AR 2, MAIN_G.
//  - car_farm_road held high -> FARM_G exactly 16 cycles, then FARM_Y; main gets >=8 cyc before next grant.
//  - 1-cycle ped_req during MAIN_G cycle 2 -> ped_pending=1; WALK at cycle 13 after release for 6 cyc
//    walk=1 with both heads RED; ped_pending=0 from WALK entry.
//  - Farm car + ped both pending at AR_GRANT -> FARM_G first (rr), next cycle round -> WALK.
//  - Car arrives then leaves during MAIN_Y -> AR_GRANT returns MAIN_G; reset asserted in FARM_Y -> MAIN_G.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes, phase encodings and head decode for the phase scheduler
package traffic_pkg;

    // Light head codes
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Phase state encodings; 3'd7 is unused and recovers to ST_MAIN_G
    localparam logic [2:0] ST_MAIN_G   = 3'd0;
    localparam logic [2:0] ST_MAIN_Y   = 3'd1;
    localparam logic [2:0] ST_AR_GRANT = 3'd2;
    localparam logic [2:0] ST_FARM_G   = 3'd3;
    localparam logic [2:0] ST_FARM_Y   = 3'd4;
    localparam logic [2:0] ST_WALK     = 3'd5;
    localparam logic [2:0] ST_AR_MAIN  = 3'd6;

    // Round-robin side to favour when farm and pedestrian both wait
    localparam logic RR_FARM = 1'b0;
    localparam logic RR_PED  = 1'b1;

    typedef struct packed {
        logic [1:0] main_road;
        logic [1:0] farm_road;
        logic       walk;
    } heads_t;

    // Moore decode of the phase; anything unrecognised shows the safe all-red
    function automatic heads_t decode_heads(input logic [2:0] st);
        heads_t h;
        h = '{main_road: RED, farm_road: RED, walk: 1'b0};
        case (st)
            ST_MAIN_G: h.main_road = GREEN;
            ST_MAIN_Y: h.main_road = YELLOW;
            ST_FARM_G: h.farm_road = GREEN;
            ST_FARM_Y: h.farm_road = YELLOW;
            ST_WALK:   h.walk      = 1'b1;
            default:   ;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating per-phase cycle counter
//  clk    in  clock
//  reset  in  synchronous reset, active-low
//  clr    in  restart count at 0 on the next cycle (phase change)
//  cnt    out cycles spent in the current phase, saturating at all-ones
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - timed main/farm/pedestrian phase scheduler
//  clk            in   clock
//  reset          in   synchronous reset, active-low
//  car_farm_road  in   farm-road car waiting (level, not latched)
//  ped_req        in   pedestrian button (latched into ped_pending)
//  Main_road      out  main head code (RED/YELLOW/GREEN)
//  Farm_road      out  farm head code
//  walk           out  walk lamp
//  ped_pending    out  latched pedestrian request awaiting service
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_farm_road,
    input  logic       ped_req,
    output logic [1:0] Main_road,
    output logic [1:0] Farm_road,
    output logic       walk,
    output logic       ped_pending
);

    localparam logic [CNT_W-1:0] MIN_G_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_G_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rr;
    logic             clr;
    heads_t           heads;

    // Any phase change restarts the timer so cnt is 0 on a phase's first cycle
    assign clr = (state_nxt != state);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .cnt   (cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_MAIN_G: begin
                if (cnt >= MIN_G_LAST && (car_farm_road || ped_pending))
                    state_nxt = ST_MAIN_Y;
            end
            ST_MAIN_Y: begin
                if (cnt == YELLOW_LAST)
                    state_nxt = ST_AR_GRANT;
            end
            ST_AR_GRANT: begin
                // Requests are re-sampled here; a car that left gives main back
                if (cnt == ALLRED_LAST) begin
                    if (car_farm_road && ped_pending)
                        state_nxt = (rr == RR_FARM) ? ST_FARM_G : ST_WALK;
                    else if (car_farm_road)
                        state_nxt = ST_FARM_G;
                    else if (ped_pending)
                        state_nxt = ST_WALK;
                    else
                        state_nxt = ST_MAIN_G;
                end
            end
            ST_FARM_G: begin
                if (cnt >= MIN_G_LAST && (!car_farm_road || cnt == MAX_G_LAST))
                    state_nxt = ST_FARM_Y;
            end
            ST_FARM_Y: begin
                if (cnt == YELLOW_LAST)
                    state_nxt = ST_AR_MAIN;
            end
            ST_WALK: begin
                if (cnt == WALK_LAST)
                    state_nxt = ST_AR_MAIN;
            end
            ST_AR_MAIN: begin
                if (cnt == ALLRED_LAST)
                    state_nxt = ST_MAIN_G;
            end
            default: state_nxt = ST_MAIN_G;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_MAIN_G;
            ped_pending <= 1'b0;
            rr          <= RR_FARM;
        end else begin
            state <= state_nxt;

            // Entering WALK serves the request; that clear beats a same-cycle press
            if (state_nxt == ST_WALK && state != ST_WALK)
                ped_pending <= 1'b0;
            else if (ped_req && state != ST_WALK)
                ped_pending <= 1'b1;

            // After serving one side, the other side wins the next tie
            if (state == ST_AR_GRANT && state_nxt == ST_FARM_G)
                rr <= RR_PED;
            else if (state == ST_AR_GRANT && state_nxt == ST_WALK)
                rr <= RR_FARM;
        end
    end

    assign heads     = decode_heads(state);
    assign Main_road = heads.main_road;
    assign Farm_road = heads.farm_road;
    assign walk      = heads.walk;

endmodule
